// File: rtl/dmem_lsu_if.sv
// Load/store request bus for the data-memory load/store unit.
// The requester drives the request fields; the memory returns the handshake,
// the response strobe with its data and error flag, and the clear-sweep status.
interface dmem_lsu_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    modport master (
        output req, we, size, uns, addr, wdata,
        input  ready, rvalid, rdata, err, busy
    );

    modport slave (
        input  req, we, size, uns, addr, wdata,
        output ready, rvalid, rdata, err, busy
    );
endinterface

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: a word-organised RAM with byte/half/word
// little-endian access, sign/zero extension, alignment and range faults,
// a configurable access delay and an optional zero sweep after reset.
//
// Timing: a request is accepted on a rising edge with req & ready. The
// response register is loaded WAIT_CYC edges after the accepting edge, so a
// consumer sampling on rising edges sees rvalid exactly WAIT_CYC+1 edges after
// acceptance. With WAIT_CYC=0 the access executes on the accepting edge itself
// and the ACCESS state is skipped; this is what allows one request every two
// cycles while ready stays confined to IDLE.
module dmem_lsu #(
    parameter logic [31:0] BASE         = 32'h1001_0000,
    parameter int          DEPTH        = 2048,
    parameter int          WAIT_CYC     = 0,
    parameter bit          CLEAR_ON_RST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    dmem_lsu_if.slave  bus
);
    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] LIMIT     = 32'(DEPTH * 4);
    localparam bit          ZERO_WAIT = (WAIT_CYC == 0);
    // The accepting edge already counts as the first wait cycle.
    localparam logic [3:0]  CNT_INIT  = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic [IDX_W-1:0]  idx_r;
    logic              op_we_r;
    logic [1:0]        op_size_r;
    logic              op_uns_r;
    logic [31:0]       op_off_r;
    logic [31:0]       op_wdata_r;
    logic              ready_r;
    logic              rvalid_r;
    logic [31:0]       rdata_r;
    logic              err_r;
    logic              busy_r;

    logic [31:0]       mem_r [DEPTH];

    logic              accept_s;
    logic              exec_s;
    logic              sweep_s;
    logic              mem_wr_s;
    logic [31:0]       live_off_s;
    logic              cur_we_s;
    logic [1:0]        cur_size_s;
    logic              cur_uns_s;
    logic [31:0]       cur_off_s;
    logic [31:0]       cur_wdata_s;
    logic [IDX_W-1:0]  word_idx_s;
    logic [1:0]        lane_s;
    logic              fault_s;
    logic [31:0]       rd_word_s;
    logic [7:0]        rd_byte_s;
    logic [15:0]       rd_half_s;
    logic [31:0]       load_s;
    logic [31:0]       resp_data_s;
    logic [3:0]        be_s;
    logic [31:0]       wr_data_s;

    // Address fault check: illegal size, misalignment, or outside the array.
    function automatic logic addr_fault(input logic [1:0] size, input logic [31:0] off);
        logic f;
        case (size)
            2'b00:   f = 1'b0;
            2'b01:   f = off[0];
            2'b10:   f = (off[1:0] != 2'b00);
            default: f = 1'b1;
        endcase
        return f | (off >= LIMIT);
    endfunction

    assign accept_s   = ready_r & bus.req;
    assign live_off_s = bus.addr - BASE;
    assign exec_s     = (accept_s & ZERO_WAIT) |
                        ((state_r == ST_ACCESS) & (cnt_r == 4'd0));
    assign sweep_s    = (state_r == ST_CLEAR) & busy_r;

    // Operand source: live bus fields when executing on the accept edge, captured copy otherwise.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_we_s    = bus.we;
            cur_size_s  = bus.size;
            cur_uns_s   = bus.uns;
            cur_off_s   = live_off_s;
            cur_wdata_s = bus.wdata;
        end else begin
            cur_we_s    = op_we_r;
            cur_size_s  = op_size_r;
            cur_uns_s   = op_uns_r;
            cur_off_s   = op_off_r;
            cur_wdata_s = op_wdata_r;
        end
    end

    assign word_idx_s = cur_off_s[IDX_W+1:2];
    assign lane_s     = cur_off_s[1:0];
    assign fault_s    = addr_fault(cur_size_s, cur_off_s);
    assign rd_word_s  = mem_r[word_idx_s];
    assign rd_byte_s  = rd_word_s[{lane_s, 3'b000} +: 8];
    assign rd_half_s  = rd_word_s[{lane_s[1], 4'b0000} +: 16];
    assign mem_wr_s   = exec_s & cur_we_s & ~fault_s;

    // Load lane extraction with sign or zero extension.
    always_comb begin
        case (cur_size_s)
            2'b00:   load_s = cur_uns_s ? {24'd0, rd_byte_s} : {{24{rd_byte_s[7]}}, rd_byte_s};
            2'b01:   load_s = cur_uns_s ? {16'd0, rd_half_s} : {{16{rd_half_s[15]}}, rd_half_s};
            2'b10:   load_s = rd_word_s;
            default: load_s = 32'd0;
        endcase
        if (fault_s || cur_we_s) begin
            resp_data_s = 32'd0;
        end else begin
            resp_data_s = load_s;
        end
    end

    // Store lane enables and lane-replicated write data.
    always_comb begin
        case (cur_size_s)
            2'b00: begin
                be_s      = 4'b0001 << lane_s;
                wr_data_s = {4{cur_wdata_s[7:0]}};
            end
            2'b01: begin
                be_s      = lane_s[1] ? 4'b1100 : 4'b0011;
                wr_data_s = {2{cur_wdata_s[15:0]}};
            end
            2'b10: begin
                be_s      = 4'b1111;
                wr_data_s = cur_wdata_s;
            end
            default: begin
                be_s      = 4'b0000;
                wr_data_s = 32'd0;
            end
        endcase
    end

    // Storage array: zero sweep or lane-masked store; the RAM itself carries no reset.
    always_ff @(posedge clk) begin
        if (sweep_s) begin
            mem_r[idx_r] <= 32'd0;
        end else if (mem_wr_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[word_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake, response and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= RST_STATE;
            cnt_r      <= 4'd0;
            idx_r      <= '0;
            op_we_r    <= 1'b0;
            op_size_r  <= 2'b00;
            op_uns_r   <= 1'b0;
            op_off_r   <= 32'd0;
            op_wdata_r <= 32'd0;
            ready_r    <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= 32'd0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            rvalid_r <= 1'b0;
            case (state_r)
                ST_CLEAR: begin
                    // First edge only raises busy; the sweep writes while busy is visible.
                    if (!busy_r) begin
                        busy_r <= 1'b1;
                    end else if (idx_r == IDX_LAST) begin
                        idx_r   <= '0;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        idx_r <= idx_r + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (accept_s) begin
                        ready_r    <= 1'b0;
                        op_we_r    <= bus.we;
                        op_size_r  <= bus.size;
                        op_uns_r   <= bus.uns;
                        op_off_r   <= live_off_s;
                        op_wdata_r <= bus.wdata;
                        if (ZERO_WAIT) begin
                            rvalid_r <= 1'b1;
                            rdata_r  <= resp_data_s;
                            err_r    <= fault_s;
                            state_r  <= ST_RESP;
                        end else begin
                            cnt_r   <= CNT_INIT;
                            state_r <= ST_ACCESS;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_r == 4'd0) begin
                        rvalid_r <= 1'b1;
                        rdata_r  <= resp_data_s;
                        err_r    <= fault_s;
                        state_r  <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ready_r <= 1'b0;
                    state_r <= RST_STATE;
                end
            endcase
        end
    end

    assign bus.ready  = ready_r;
    assign bus.rvalid = rvalid_r;
    assign bus.rdata  = rdata_r;
    assign bus.err    = err_r;
    assign bus.busy   = busy_r;
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu. Instance A: DEPTH=16, WAIT_CYC=2, cleared after reset.
// Instance B: DEPTH=16, WAIT_CYC=0, no clear, driven back-to-back.
// Stimulus pushes expected responses into queues; monitor processes pop and
// compare on every rvalid. Reference model is a byte array with the access
// rules applied directly.
module tb_dmem_lsu;
    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam int DEPTH = 16;
    localparam int WAIT_A = 2;

    typedef struct {
        logic [31:0] rd;
        logic        e;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [7:0]  mem_m [DEPTH*4];
    logic [31:0] mem_b [DEPTH];
    int          prev_b = -1;

    dmem_lsu_if bus_a();
    dmem_lsu_if bus_b();

    dmem_lsu #(.BASE(BASE), .DEPTH(DEPTH), .WAIT_CYC(WAIT_A), .CLEAR_ON_RST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    dmem_lsu #(.BASE(BASE), .DEPTH(DEPTH), .WAIT_CYC(0), .CLEAR_ON_RST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic record_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: apply the access rules to a byte-addressed memory.
    task automatic model_a(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic e);
        logic [31:0] off;
        logic [31:0] v;
        int n;
        off = addr - BASE;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        e = (size == 2'd3) || ((off % 32'(n)) != 32'd0) || (off >= 32'(DEPTH * 4));
        rd = 32'd0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < n; i++) mem_m[off[5:0] + 6'(i)] = wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[off[5:0] + 6'(i)];
                if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                rd = v;
            end
        end
    endtask

    task automatic issue_a(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        exp_t x;
        int n;
        n = 0;
        @(negedge clk);
        bus_a.we = we; bus_a.size = size; bus_a.uns = uns;
        bus_a.addr = addr; bus_a.wdata = wdata; bus_a.req = 1'b1;
        while (!bus_a.ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus_a.ready) begin
            record_fail("a accept timeout");
            bus_a.req = 1'b0;
            return;
        end
        model_a(we, size, uns, addr, wdata, x.rd, x.e);
        x.acc = cyc + 1;
        q_a.push_back(x);
        @(posedge clk);
        #1;
        // Post-accept changes must not influence the captured request.
        bus_a.req = 1'b0;
        bus_a.we = $urandom_range(0, 1) != 0;
        bus_a.size = 2'($urandom_range(0, 3));
        bus_a.uns = $urandom_range(0, 1) != 0;
        bus_a.addr = $urandom;
        bus_a.wdata = $urandom;
    endtask

    task automatic issue_b(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t x;
        int n;
        logic [31:0] off;
        n = 0;
        @(negedge clk);
        bus_b.we = we; bus_b.size = 2'b10; bus_b.uns = 1'b0;
        bus_b.addr = addr; bus_b.wdata = wdata; bus_b.req = 1'b1;
        while (!bus_b.ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus_b.ready) begin
            record_fail("b accept timeout");
            return;
        end
        off = addr - BASE;
        x.e = (off[1:0] != 2'b00) || (off >= 32'(DEPTH * 4));
        x.rd = 32'd0;
        if (!x.e) begin
            if (we) mem_b[off[5:2]] = wdata;
            else x.rd = mem_b[off[5:2]];
        end
        x.acc = cyc + 1;
        if (prev_b >= 0) check("b accept spacing", 32'(x.acc - prev_b), 32'd2);
        prev_b = x.acc;
        q_b.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q_a.size() != 0 || q_b.size() != 0) record_fail("response timeout");
    endtask

    task automatic release_and_sweep;
        int n;
        int busy_cnt;
        n = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("a busy after first edge", 32'(bus_a.busy), 32'd1);
        check("a ready during sweep", 32'(bus_a.ready), 32'd0);
        busy_cnt = 1;
        while (!bus_a.ready && n < 100) begin
            @(negedge clk);
            n++;
            if (bus_a.busy) busy_cnt++;
        end
        if (!bus_a.ready) record_fail("a sweep timeout");
        check("a busy cycles", 32'(busy_cnt), 32'd16);
        check("a busy low in idle", 32'(bus_a.busy), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] addr;
        logic [1:0]  size;
        int          sel;

        bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.size = 2'b00; bus_a.uns = 1'b0;
        bus_a.addr = 32'd0; bus_a.wdata = 32'd0;
        bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.size = 2'b10; bus_b.uns = 1'b0;
        bus_b.addr = 32'd0; bus_b.wdata = 32'd0;
        for (int i = 0; i < DEPTH * 4; i++) mem_m[i] = 8'h00;

        fork
            // Monitor A: scoreboard compare, latency, and hold of rdata/err between responses.
            begin
                exp_t xa;
                logic [31:0] last_rd;
                logic        last_e;
                last_rd = 32'd0;
                last_e = 1'b0;
                forever begin
                    @(negedge clk);
                    if (!rst) begin
                        last_rd = 32'd0;
                        last_e = 1'b0;
                        check("a reset outputs",
                              {27'd0, bus_a.ready, bus_a.rvalid, bus_a.err, bus_a.busy, |bus_a.rdata}, 32'd0);
                    end else if (bus_a.rvalid) begin
                        if (q_a.size() == 0) begin
                            record_fail("a rvalid with no request outstanding");
                        end else begin
                            xa = q_a.pop_front();
                            check("a rdata", bus_a.rdata, xa.rd);
                            check("a err", 32'(bus_a.err), 32'(xa.e));
                            check("a latency", 32'(cyc), 32'(xa.acc + WAIT_A));
                        end
                        last_rd = bus_a.rdata;
                        last_e = bus_a.err;
                    end else begin
                        check("a rdata hold", bus_a.rdata, last_rd);
                        check("a err hold", 32'(bus_a.err), 32'(last_e));
                    end
                end
            end
            // Monitor B: scoreboard compare and zero-wait latency.
            begin
                exp_t xb;
                forever begin
                    @(negedge clk);
                    if (!rst) begin
                        check("b reset outputs",
                              {28'd0, bus_b.ready, bus_b.rvalid, bus_b.err, |bus_b.rdata}, 32'd0);
                    end else if (bus_b.rvalid) begin
                        if (q_b.size() == 0) begin
                            record_fail("b rvalid with no request outstanding");
                        end else begin
                            xb = q_b.pop_front();
                            check("b rdata", bus_b.rdata, xb.rd);
                            check("b err", 32'(bus_b.err), 32'(xb.e));
                            check("b latency", 32'(cyc), 32'(xb.acc));
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        release_and_sweep();
        check("b ready without clear", 32'(bus_b.ready), 32'd1);

        // Swept array reads back zero at the top word.
        issue_a(1'b0, 2'b10, 1'b0, BASE + 32'h3C, 32'd0);
        // Sign/zero-extended byte and half loads from a stored word.
        issue_a(1'b1, 2'b10, 1'b0, BASE + 32'h08, 32'h8081_82F0);
        issue_a(1'b0, 2'b00, 1'b0, BASE + 32'h08, 32'd0);
        issue_a(1'b0, 2'b00, 1'b1, BASE + 32'h08, 32'd0);
        issue_a(1'b0, 2'b01, 1'b0, BASE + 32'h0A, 32'd0);
        // Byte store into the middle of an existing word.
        issue_a(1'b1, 2'b10, 1'b0, BASE + 32'h04, 32'h1122_3344);
        issue_a(1'b1, 2'b00, 1'b0, BASE + 32'h05, 32'hFFFF_FFAA);
        issue_a(1'b0, 2'b10, 1'b0, BASE + 32'h04, 32'd0);
        // Faulting requests, then confirm nothing was written.
        issue_a(1'b1, 2'b10, 1'b0, BASE + 32'h06, 32'hCAFE_F00D);
        issue_a(1'b0, 2'b01, 1'b0, BASE + 32'h03, 32'd0);
        issue_a(1'b0, 2'b11, 1'b0, BASE + 32'h00, 32'd0);
        issue_a(1'b1, 2'b10, 1'b0, BASE + 32'h40, 32'h5555_5555);
        issue_a(1'b0, 2'b10, 1'b0, BASE - 32'h4, 32'd0);
        issue_a(1'b0, 2'b10, 1'b0, BASE + 32'h04, 32'd0);
        issue_a(1'b0, 2'b10, 1'b0, BASE + 32'h08, 32'd0);

        // Random mix of sizes, alignments and out-of-range addresses.
        for (int k = 0; k < 200; k++) begin
            sel = $urandom_range(0, 9);
            size = (sel < 9) ? 2'(sel % 3) : 2'b11;
            sel = $urandom_range(0, 19);
            if (sel == 0) addr = BASE - 32'($urandom_range(1, 8));
            else addr = BASE + 32'($urandom_range(0, 71));
            if ($urandom_range(0, 1) != 0 && size == 2'b01) addr[0] = 1'b0;
            if ($urandom_range(0, 1) != 0 && size == 2'b10) addr[1:0] = 2'b00;
            r = $urandom;
            issue_a($urandom_range(0, 2) == 0, size, $urandom_range(0, 1) != 0, addr, r);
        end
        drain();

        // Zero-wait, no-clear instance with req held high throughout.
        for (int k = 0; k < 8; k++) issue_b(1'b1, BASE + 32'(8 * k), $urandom);
        for (int k = 0; k < 8; k++) issue_b(1'b0, BASE + 32'(8 * $urandom_range(0, 7)), 32'd0);
        issue_b(1'b0, BASE + 32'h40, 32'd0);
        issue_b(1'b0, BASE + 32'h10, 32'd0);
        bus_b.req = 1'b0;
        drain();

        // Reset in the middle of a store's wait cycles: no response, swept afterwards.
        @(negedge clk);
        bus_a.we = 1'b1; bus_a.size = 2'b10; bus_a.uns = 1'b0;
        bus_a.addr = BASE; bus_a.wdata = 32'hDEAD_BEEF; bus_a.req = 1'b1;
        sel = 0;
        while (!bus_a.ready && sel < 200) begin
            @(negedge clk);
            sel++;
        end
        if (!bus_a.ready) record_fail("a abort accept timeout");
        @(posedge clk);
        #1;
        bus_a.req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("a rvalid in reset", 32'(bus_a.rvalid), 32'd0);
        check("a ready in reset", 32'(bus_a.ready), 32'd0);
        for (int i = 0; i < DEPTH * 4; i++) mem_m[i] = 8'h00;
        repeat (4) @(negedge clk);
        release_and_sweep();
        issue_a(1'b0, 2'b10, 1'b0, BASE, 32'd0);
        issue_a(1'b0, 2'b10, 1'b0, BASE + 32'h08, 32'd0);
        drain();
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
